// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and threshold checks for the sync FIFO
package fifo_pkg;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of storage entries for a given address width
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Pointers carry one extra wrap bit above the address bits
  function automatic int ptr_w_of(input int addr_w);
    return addr_w + 1;
  endfunction

  // Legal thresholds: almost_full level in 1..DEPTH, almost_empty level in 0..DEPTH-1
  function automatic bit levels_ok(input int addr_w, input int af, input int ae);
    return (af >= 1) && (af <= depth_of(addr_w)) && (ae >= 0) && (ae < depth_of(addr_w));
  endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// rtl/fifo_ram_sp.sv - DEPTH x DATA_W simple dual-port RAM, registered read
module fifo_ram_sp
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: contents are never cleared by reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: output register resets to zero and holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO with registered status and sticky error flags
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int PTR_W = ptr_w_of(ADDR_W);

  if (!levels_ok(ADDR_W, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("fifo_sync_ctrl: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
  end
  if (clog2(DEPTH + 1) != PTR_W) begin : g_bad_width
    $error("fifo_sync_ctrl: pointer width cannot represent occupancy 0..DEPTH");
  end

  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W-1:0] wptr_nxt, rptr_nxt, cnt_nxt;
  logic             wr_accept, rd_accept;

  // Accept decisions use registered full/empty; status is derived from next-state pointers
  always_comb begin
    wr_accept = wr_en & ~full;
    rd_accept = rd_en & ~empty;
    wptr_nxt  = wptr + PTR_W'(wr_accept);
    rptr_nxt  = rptr + PTR_W'(rd_accept);
    cnt_nxt   = wptr_nxt - rptr_nxt;
  end

  // Pointer, status and sticky error registers; a new error wins over err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      count        <= cnt_nxt;
      empty        <= (wptr_nxt == rptr_nxt);
      full         <= (wptr_nxt[ADDR_W-1:0] == rptr_nxt[ADDR_W-1:0]) &&
                      (wptr_nxt[ADDR_W] != rptr_nxt[ADDR_W]);
      almost_full  <= (cnt_nxt >= PTR_W'(AF_LEVEL));
      almost_empty <= (cnt_nxt <= PTR_W'(AE_LEVEL));
      rd_valid     <= rd_accept;
      overflow     <= (wr_en & full) | (overflow & ~err_clr);
      underflow    <= (rd_en & empty) | (underflow & ~err_clr);
    end
  end

  fifo_ram_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_accept & ~rst),
    .waddr(wptr[ADDR_W-1:0]),
    .wdata(wr_data),
    .re   (rd_accept),
    .raddr(rptr[ADDR_W-1:0]),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - directed vector bench for fifo_sync_ctrl
module tb_fifo_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, err_clr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic        w2, r2;
  logic [15:0] d2, q2;
  logic        rv2, full2, empty2, af2, ae2, ovf2, udf2;
  logic [2:0]  count2;

  always #5 clk = ~clk;

  fifo_sync_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  fifo_sync_ctrl #(.DATA_W(16), .ADDR_W(2), .AF_LEVEL(4), .AE_LEVEL(0)) dut2 (
    .clk(clk), .rst(rst), .wr_en(w2), .wr_data(d2), .rd_en(r2),
    .rd_data(q2), .rd_valid(rv2), .full(full2), .empty(empty2),
    .almost_full(af2), .almost_empty(ae2), .count(count2),
    .overflow(ovf2), .underflow(udf2), .err_clr(1'b0)
  );

  typedef struct {
    logic       rst, wr, rd, clr;
    logic [7:0] wd;
    int         exp_cnt;
    logic       exp_ovf, exp_udf, exp_rv;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic r, w, rd, c, input logic [7:0] wd,
                              input int cnt, input logic ovf, udf, rv, input logic [7:0] dat);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.clr = c; v.wd = wd;
    v.exp_cnt = cnt; v.exp_ovf = ovf; v.exp_udf = udf; v.exp_rv = rv; v.exp_data = dat;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, w, rd, c, input logic [7:0] wd);
    rst = r; wr_en = w; rd_en = rd; err_clr = c; wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  // Status flags of the default instance follow from occupancy with levels 14 / 2
  task automatic check_status(input string tag, input int c, input logic ovf, udf, rv);
    check({tag, " count"}, 32'(count), 32'(c));
    check({tag, " full"}, 32'(full), 32'(c == 16));
    check({tag, " empty"}, 32'(empty), 32'(c == 0));
    check({tag, " almost_full"}, 32'(almost_full), 32'(c >= 14));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= 2));
    check({tag, " overflow"}, 32'(overflow), 32'(ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(udf));
    check({tag, " rd_valid"}, 32'(rd_valid), 32'(rv));
  endtask

  task automatic step2(input logic w, r, input logic [15:0] d);
    w2 = w; r2 = r; d2 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e;
    w2 = 1'b0; r2 = 1'b0; d2 = '0;

    // Reset, fill, overflow, drain, underflow, clear
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 8'(i), i + 1, 0, 0, 0, 8'h00);
    add(0, 1, 0, 0, 8'hAA, 16, 1, 0, 0, 8'h00);
    for (int j = 0; j < 16; j++) add(0, 0, 1, 0, 8'h00, 15 - j, 1, 0, 1, 8'(j));
    add(0, 0, 1, 0, 8'h00, 0, 1, 1, 0, 8'h00);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00);

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k].rst, vecs[k].wr, vecs[k].rd, vecs[k].clr, vecs[k].wd);
      check_status($sformatf("vec%0d", k), vecs[k].exp_cnt, vecs[k].exp_ovf,
                   vecs[k].exp_udf, vecs[k].exp_rv);
      if (vecs[k].exp_rv)
        check($sformatf("vec%0d rd_data", k), 32'(rd_data), 32'(vecs[k].exp_data));
    end

    // Overflow concurrent with err_clr: set wins
    for (int i = 0; i < 16; i++) apply(0, 1, 0, 0, 8'(8'h10 + i));
    apply(0, 1, 0, 1, 8'hCC);
    check_status("ovf_vs_clr", 16, 1, 0, 0);

    // Full with both requests: read accepted, write rejected
    apply(0, 0, 0, 1, 8'h00);
    check_status("clr_full", 16, 0, 0, 0);
    apply(0, 1, 1, 0, 8'hBB);
    check_status("both_full", 15, 1, 0, 1);
    check("both_full rd_data", 32'(rd_data), 32'h10);
    for (int k = 0; k < 15; k++) begin
      apply(0, 0, 1, 0, 8'h00);
      check($sformatf("drain_full%0d rd_data", k), 32'(rd_data), 32'(8'h11 + k));
    end
    check_status("drained", 0, 1, 0, 1);

    // Empty with both requests: write accepted, read rejected, no bypass
    apply(0, 0, 0, 1, 8'h00);
    apply(0, 1, 1, 0, 8'h55);
    check_status("both_empty", 1, 0, 1, 0);
    apply(0, 0, 1, 0, 8'h00);
    check_status("read_55", 0, 0, 1, 1);
    check("read_55 rd_data", 32'(rd_data), 32'h55);

    // Steady streaming at occupancy 5 across several pointer wraps
    apply(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      q.push_back(8'(8'h30 + i));
      apply(0, 1, 0, 0, 8'(8'h30 + i));
    end
    check_status("stream_pre", 5, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      q.push_back(8'(8'h40 + k));
      e = q.pop_front();
      apply(0, 1, 1, 0, 8'(8'h40 + k));
      check($sformatf("stream%0d count", k), 32'(count), 32'd5);
      check($sformatf("stream%0d rd_valid", k), 32'(rd_valid), 32'd1);
      check($sformatf("stream%0d rd_data", k), 32'(rd_data), 32'(e));
    end
    for (int k = 0; k < 5; k++) begin
      e = q.pop_front();
      apply(0, 0, 1, 0, 8'h00);
      check($sformatf("stream_tail%0d rd_data", k), 32'(rd_data), 32'(e));
    end
    check_status("stream_end", 0, 0, 0, 1);

    // Reset mid-operation discards stored words
    for (int i = 0; i < 9; i++) apply(0, 1, 0, 0, 8'(8'h60 + i));
    check_status("pre_rst", 9, 0, 0, 0);
    apply(1, 1, 1, 0, 8'h99);
    check_status("mid_rst", 0, 0, 0, 0);
    check("mid_rst rd_data", 32'(rd_data), 32'h00);
    apply(0, 1, 0, 0, 8'h77);
    check_status("post_rst_wr", 1, 0, 0, 0);
    apply(0, 0, 1, 0, 8'h00);
    check_status("post_rst_rd", 0, 0, 0, 1);
    check("post_rst_rd rd_data", 32'(rd_data), 32'h77);
    apply(0, 0, 0, 0, 8'h00);

    // Small instance: DEPTH 4, AF 4, AE 0
    check("p2 reset empty", 32'(empty2), 32'd1);
    check("p2 reset almost_empty", 32'(ae2), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step2(1, 0, 16'(16'h1000 + i));
      check($sformatf("p2 wr%0d count", i), 32'(count2), 32'(i + 1));
      check($sformatf("p2 wr%0d full", i), 32'(full2), 32'(i == 3));
      check($sformatf("p2 wr%0d almost_full", i), 32'(af2), 32'(i == 3));
      check($sformatf("p2 wr%0d almost_empty", i), 32'(ae2), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step2(0, 1, 16'h0000);
      check($sformatf("p2 rd%0d rd_data", i), 32'(q2), 32'(16'h1000 + i));
      check($sformatf("p2 rd%0d rd_valid", i), 32'(rv2), 32'd1);
      check($sformatf("p2 rd%0d almost_empty", i), 32'(ae2), 32'(i == 3));
      check($sformatf("p2 rd%0d empty", i), 32'(empty2), 32'(i == 3));
    end
    check("p2 overflow", 32'(ovf2), 32'd0);
    check("p2 underflow", 32'(udf2), 32'd0);
    step2(0, 0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
